axis_pcie_txs_arb: RTL
======================

# axis_pcie_txs_arb

Packet-aware N:1 arbiter for the PCIe TX AXI-S path (`t_axis_pcie_txs`). It shares the single host-bound TX stream between several requesters, such as the MMIO-completion, DMA and interrupt/message sources. It sits upstream of the TX pipeline register chain. A grant is held from the first beat of a TLP until the handshake on its `tlast` beat, so TLPs from different sources never interleave.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of requesters, 2–16.
- `ARB_MODE`, default 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `s_if` in `t_axis_pcie_txs [NUM_PORTS-1:0]`: requester streams (tvalid, tdata, tlast, tuser).
- `s_if_tready` out `[NUM_PORTS-1:0]`: per-requester ready.
- `m_if` out `t_axis_pcie_txs`: arbitrated stream.
- `m_if_tready` in 1: downstream ready.
- `grant` out `[NUM_PORTS-1:0]`: one-hot current owner; 0 when idle.
- `busy` out 1: a packet is in progress.

## Operation
- Two-state FSM: IDLE and BUSY.
- IDLE:
  - `s_if_tready` = 0, `m_if` all fields 0, `grant` = 0.
  - Requests are the per-port `s_if[i].tvalid` bits. If any request is set, the winner is registered into `grant` and the FSM moves to BUSY.
- Round-robin (`ARB_MODE` = 0):
  - Search starts at `rr_ptr`, incrementing and wrapping at `NUM_PORTS-1`.
  - On each grant, `rr_ptr` becomes the winner index + 1, mod `NUM_PORTS`.
- Fixed priority (`ARB_MODE` = 1): lowest asserted index wins; `rr_ptr` is unused.
- BUSY, owner g:
  - `m_if` = `s_if[g]` (combinational mux).
  - `s_if_tready[g]` = `m_if_tready`; all other readys are 0.
- Packet end: a beat with `s_if[g].tvalid & m_if_tready & s_if[g].tlast` returns the FSM to IDLE on the next edge, and `grant` clears.
- Owner drops tvalid mid-packet: stay in BUSY and keep the grant; never re-arbitrate mid-TLP.
- Single-beat packet (tlast on the first beat): legal; one BUSY cycle if ready.
- Requests arriving while BUSY are ignored until IDLE.
- No upstream protocol checking. A requester that never asserts `tlast` holds the grant indefinitely; this is documented behaviour.
- Reset assertion at any time:
  - FSM to IDLE, `grant` = 0, `rr_ptr` = 0.
  - `s_if_tready` = 0, `m_if.tvalid` = 0; an in-flight packet is abandoned.

## Timing
Reset values:
- `s_if_tready` = 0, `m_if` = 0, `grant` = 0, `busy` = 0, `rr_ptr` = 0.

Arbitration and throughput:
- Arbitration latency is 1 cycle. A request visible at edge N yields BUSY, `grant` and `m_if.tvalid` during cycle N+1.
- The first beat transfers in cycle N+1 if `m_if_tready` = 1.
- An N-beat packet with continuous valid and ready occupies N+1 cycles: one IDLE arbitration cycle, then N BUSY cycles.
- The IDLE bubble between packets is mandatory.

Combinational paths:
- `m_if_tready` to `s_if_tready` is combinational (one AND per port).
- `s_if[g]` to `m_if` is a combinational mux.
- Registering is provided by the downstream pipeline register.

Registered outputs:
- `grant` and `busy` come directly from flops; `busy` = (state == BUSY).
- No output depends combinationally on `s_if[*].tvalid` in IDLE.

Backpressure:
- `m_if_tready` = 0 holds the current beat. The owner must hold its data (AXI-S rule), and the arbiter adds no storage.

## Test plan
- **Single requester:** port 2 sends a 3-beat TLP (tdata 0xA, 0xB, 0xC; tlast on beat 3), `m_if_tready` = 1.
  - `grant` = 4'b0100 for 3 cycles after a 1-cycle bubble.
  - `m_if` carries A, B, C with tlast on C, then returns to IDLE.
- **Round-robin fairness:** all 4 ports continuously offer 2-beat TLPs.
  - Grant order is 0, 1, 2, 3, 0, …
  - Each packet takes 3 cycles.
  - No beats are interleaved (checked by scoreboard per source).
- **Fixed priority:** with `ARB_MODE` = 1, ports 1 and 3 request continuously.
  - Port 1 wins every arbitration and port 3 starves.
  - After port 1 deasserts, port 3 is granted 1 cycle after the next IDLE.
- **Backpressure and gaps:** port 0 sends a 4-beat TLP.
  - Toggle `m_if_tready` 1,0,0,1,1,0,1 and insert a 2-cycle tvalid gap after beat 2.
  - `grant` stays 0001 throughout and all 4 beats arrive in order.
  - Ports 1–3, which request during the gap, see tready = 0.
- **Reset mid-packet:** assert `rst_n` low during beat 2 of a 5-beat packet from port 1.
  - Asynchronously, `m_if.tvalid` = 0, `grant` = 0 and all `s_if_tready` = 0.
  - After release, with port 3 requesting, round-robin starts from `rr_ptr` = 0 and port 3 is granted.
- **Single-beat back-to-back:** port 0 sends three 1-beat TLPs while port 1 is idle.
  - The pattern grant / IDLE / grant / IDLE repeats, giving 2 cycles per packet.

Source files
------------

// File: rtl/axis_pcie_txs_arb.sv
// axis_pcie_txs_arb: packet-aware N:1 arbiter for the host-bound PCIe TX AXI-S stream.
// A requester keeps ownership from its first beat until the handshake on its tlast beat,
// so TLPs from different sources never interleave on the shared stream.

package axis_pcie_txs_pkg;
    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic        tlast;
        logic [7:0]  tuser;
    } t_axis_pcie_txs;
endpackage

module axis_pcie_txs_arb
    import axis_pcie_txs_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ARB_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  t_axis_pcie_txs [NUM_PORTS-1:0]   s_if,
    output logic [NUM_PORTS-1:0]             s_if_tready,
    output t_axis_pcie_txs                   m_if,
    input  logic                             m_if_tready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     owner_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_ptr_nxt;
    logic [NUM_PORTS-1:0] req;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       cand;
    logic                 pkt_end;

    // Requests are simply the per-port valid bits.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = s_if[i].tvalid;
        end
    end

    // Pick the winner: scan from rr_ptr with wrap in round-robin, from index 0 in fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 1) begin
                cand = (IDX_W+1)'(k);
            end else begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                    cand = cand - (IDX_W+1)'(NUM_PORTS);
                end
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The owner's tlast handshake closes the packet.
    assign pkt_end = (state == ST_BUSY) && s_if[owner].tvalid && m_if_tready && s_if[owner].tlast;

    // Next-state logic plus the combinational data mux and ready steering.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        m_if        = '0;
        s_if_tready = '0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_nxt          = ST_BUSY;
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    owner_nxt          = win_idx;
                    if (ARB_MODE == 0) begin
                        if (win_idx == IDX_W'(NUM_PORTS-1)) begin
                            rr_ptr_nxt = '0;
                        end else begin
                            rr_ptr_nxt = win_idx + 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                m_if               = s_if[owner];
                s_if_tready[owner] = m_if_tready;
                if (pkt_end) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State, grant, owner index and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign busy = (state == ST_BUSY);

endmodule
